// File: rtl/viterbi_tb_ctrl_213_pkg.sv
// viterbi_tb_ctrl_213_pkg: shared widths and traceback FSM encodings for the (2,1,3) controller
package viterbi_tb_ctrl_213_pkg;
    localparam int W        = 8;
    localparam int M        = 3;
    localparam int N_STATES = 8;
    localparam int TB_LEN   = 16;
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_MERGE  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EMIT   = 2'd3
    } tb_state_e;
endpackage

// File: rtl/viterbi_tb_ctrl_213_argmin.sv
// viterbi_tb_ctrl_213_argmin: index of the smallest of 8 path metrics, lowest index wins ties
module viterbi_tb_ctrl_213_argmin
    import viterbi_tb_ctrl_213_pkg::*;
(
    input  logic [N_STATES*W-1:0] pm,
    output logic [M-1:0]          idx
);
    logic [W-1:0] best;
    always_comb begin
        idx  = '0;
        best = pm[W-1:0];
        for (int s = 1; s < N_STATES; s++)
            if (pm[s*W +: W] < best) begin
                best = pm[s*W +: W];
                idx  = M'(s);
            end
    end
endmodule

// File: rtl/viterbi_tb_ctrl_213.sv
// viterbi_tb_ctrl_213: survivor buffering, min-metric start selection, merge/decode traceback and bit emit
module viterbi_tb_ctrl_213
    import viterbi_tb_ctrl_213_pkg::*;
#(
    parameter int TB_LEN = viterbi_tb_ctrl_213_pkg::TB_LEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_STATES-1:0]   in_dec,
    input  logic [N_STATES*W-1:0] in_pm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  tb_busy
);
    localparam int D  = 2 * TB_LEN;
    localparam int PW = $clog2(D);
    localparam int KW = TB_LEN > 1 ? $clog2(TB_LEN) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(D - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TB_LEN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(TB_LEN - 1);

    tb_state_e           st, st_nxt;
    logic [N_STATES-1:0] mem [D];
    logic [TB_LEN-1:0]   obuf;
    logic [PW-1:0]       wr_ptr, rd_ptr, new_cnt;
    logic [KW-1:0]       cnt;
    logic [M-1:0]        s, s_min;
    logic                filled, take, fire, step, last;

    viterbi_tb_ctrl_213_argmin u_argmin (
        .pm  (in_pm),
        .idx (s_min)
    );

    assign take = in_valid && in_ready;
    assign fire = take && (new_cnt == (filled ? P_HALF : P_LAST));
    assign step = st == ST_MERGE || st == ST_DECODE;
    assign last = cnt == K_LAST;

    always_comb begin
        in_ready  = st == ST_ACCEPT;
        out_valid = st == ST_EMIT;
        out_bit   = out_valid && obuf[cnt];
        tb_busy   = st != ST_ACCEPT;
        st_nxt    = st;
        case (st)
            ST_ACCEPT: st_nxt = fire ? ST_MERGE : ST_ACCEPT;
            ST_MERGE:  st_nxt = last ? ST_DECODE : ST_MERGE;
            ST_DECODE: st_nxt = last ? ST_EMIT : ST_DECODE;
            default:   st_nxt = last && out_ready ? ST_ACCEPT : ST_EMIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= ST_ACCEPT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            new_cnt <= '0;
            filled  <= 1'b0;
            cnt     <= '0;
            s       <= '0;
        end else begin
            st <= st_nxt;
            if (take) begin
                wr_ptr  <= wr_ptr == P_LAST ? '0 : wr_ptr + PW'(1);
                new_cnt <= fire ? '0 : new_cnt + PW'(1);
            end
            if (fire) begin
                filled <= 1'b1;
                s      <= s_min;
                rd_ptr <= wr_ptr;
                cnt    <= '0;
            end
            if (step) begin
                s      <= {mem[rd_ptr][s], s[M-1:1]};
                rd_ptr <= rd_ptr == '0 ? P_LAST : rd_ptr - PW'(1);
            end
            if (step || (out_valid && out_ready))
                cnt <= last ? '0 : cnt + KW'(1);
        end
    end

    // Decode fills the buffer newest-first so index 0 ends up as the oldest bit.
    always_ff @(posedge clk) begin
        if (take)
            mem[wr_ptr] <= in_dec;
        if (st == ST_DECODE)
            obuf[K_LAST - cnt] <= s[0];
    end
endmodule

// File: tb/tb_viterbi_tb_ctrl_213.sv
// tb_viterbi_tb_ctrl_213: randomized scoreboard bench with a history-based traceback reference
module tb_viterbi_tb_ctrl_213;
    import viterbi_tb_ctrl_213_pkg::*;
    localparam int L = 4;

    logic           clk = 0, reset_n = 0, in_valid = 0, out_ready = 0;
    logic           in_ready, out_valid, out_bit, tb_busy;
    logic [7:0]     in_dec = '0;
    logic [8*W-1:0] in_pm = '0;
    int             total = 0, bad = 0, phase = 0, cnt = 0;
    logic [7:0]     hist_dec [$];
    logic [8*W-1:0] hist_pm [$];
    bit             exp_q [$];
    bit             keep = 0, stall = 0, expire = 0, expire_seen = 0;
    logic [2:0]     true_s = '0;

    viterbi_tb_ctrl_213 #(.TB_LEN(L)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_pm     (in_pm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .tb_busy   (tb_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference: start at the min-metric state of the newest step, walk back 2L steps,
    // and queue the bits of the oldest L steps oldest-first.
    task automatic trace();
        int             n = hist_dec.size();
        logic [8*W-1:0] p = hist_pm[n-1];
        logic [W-1:0]   best = p[W-1:0];
        logic [2:0]     s = '0;
        bit             bits [$];
        for (int i = 1; i < 8; i++)
            if (p[i*W +: W] < best) begin
                best = p[i*W +: W];
                s = 3'(i);
            end
        for (int j = 0; j < 2*L; j++) begin
            logic [7:0] d;
            d = hist_dec[n-1-j];
            if (j >= L) bits.push_front(s[0]);
            s = {d[s], s[2:1]};
        end
        foreach (bits[k]) exp_q.push_back(bits[k]);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_bit", out_bit, 0);
            chk("rst_busy", tb_busy, 0);
            hist_dec.delete();
            hist_pm.delete();
            exp_q.delete();
            phase = 0;
        end else if (phase == 0) begin
            chk("acc_in_ready", in_ready, 1);
            chk("acc_out_valid", out_valid, 0);
            chk("acc_busy", tb_busy, 0);
            if (in_valid && in_ready) begin
                hist_dec.push_back(in_dec);
                hist_pm.push_back(in_pm);
                if (hist_dec.size() >= 2*L && (hist_dec.size() - 2*L) % L == 0) begin
                    trace();
                    phase = 1;
                    cnt = 2*L;
                end
            end
        end else if (phase == 1) begin
            chk("tb_in_ready", in_ready, 0);
            chk("tb_out_valid", out_valid, 0);
            chk("tb_busy", tb_busy, 1);
            cnt--;
            if (cnt == 0) begin
                phase = 2;
                cnt = L;
            end
        end else begin
            chk("emit_valid", out_valid, 1);
            chk("emit_in_ready", in_ready, 0);
            chk("emit_busy", tb_busy, 1);
            if (exp_q.size() == 0)
                chk("emit_unexpected", out_valid, 0);
            else begin
                chk("out_bit", out_bit, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    cnt--;
                    if (cnt == 0) phase = 0;
                end
            end
        end
        if (expire && !expire_seen) begin
            expire_seen = 1;
            chk("drain_timeout", phase + exp_q.size(), 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic [8*W-1:0] p);
        in_valid = 1;
        in_dec   = d;
        in_pm    = p;
        @(negedge clk);
        for (int t = 0; !in_ready && t < 100; t++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = keep;
    endtask

    // Decisions keep the true encoder path intact; other states get random decisions.
    task automatic ideal(input bit u, input bit tie);
        logic [2:0]     prev = true_s;
        logic [7:0]     d = 8'($urandom);
        logic [8*W-1:0] p;
        true_s = {prev[1:0], u};
        d[true_s] = prev[2];
        for (int i = 0; i < 8; i++)
            p[i*W +: W] = tie ? W'(3) : (3'(i) == true_s ? '0 : W'($urandom_range(1, 255)));
        send(d, p);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((phase != 0 || exp_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) expire = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        true_s = '0;
    endtask

    initial begin
        logic [7:0] pat = 8'b0100_1101;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (8) send(8'h00, {{7{8'd5}}, 8'd0});
        wait_idle();
        do_reset();
        for (int i = 0; i < 12; i++) ideal(i < 8 ? pat[i] : 1'($urandom), 1'b0);
        wait_idle();
        for (int i = 0; i < 4; i++) ideal(1'($urandom), i == 3);
        wait_idle();
        for (int i = 0; i < 4; i++) ideal(1'($urandom), 1'b0);
        for (int t = 0; !(out_valid && out_ready) && t < 100; t++) @(negedge clk);
        @(posedge clk);
        #1 stall = 1;
        repeat (5) @(posedge clk);
        #1 stall = 0;
        wait_idle();
        keep = 1;
        for (int i = 0; i < 12; i++) ideal(1'($urandom), 1'b0);
        keep = 0;
        in_valid = 0;
        wait_idle();
        for (int i = 0; i < 4; i++) ideal(1'($urandom), 1'b0);
        repeat (L + 1) @(posedge clk);
        #2 reset_n = 0;
        @(posedge clk);
        #1 reset_n = 1;
        true_s = '0;
        for (int i = 0; i < 8; i++) ideal(1'($urandom), 1'b0);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            logic [8*W-1:0] p;
            for (int k = 0; k < 8; k++) p[k*W +: W] = W'($urandom_range(0, 3));
            send(8'($urandom), p);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
